sram_1rw1r_param: RTL and testbench
===================================

Name: sram_1rw1r_param

Overview:
Parametrised single-clock 1RW+1R synchronous SRAM model, the successor to the fixed 32x256 byte-masked macro model. It adds:
- generic width, depth and mask granularity;
- asynchronous reset with post-reset memory initialisation;
- per-port read-valid flags;
- an optional output pipeline register;
- a selectable read/write collision policy.

It is the storage element behind the FIFO and buffer blocks.

Parameters:
DATA_WIDTH, 32, word width in bits; must be divisible by WMASK_WIDTH.
ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH.
WMASK_WIDTH, 4, write-mask bits; each bit covers DATA_WIDTH/WMASK_WIDTH bits.
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
COLLISION_MODE, 0, 0 = port 1 returns old data on a same-address write; 1 = port 1 returns merged new data.
INIT_ON_RESET, 1, 1 = write INIT_VALUE to every word after reset.
INIT_VALUE, 0, DATA_WIDTH-wide initialisation word.

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  asynchronous, active-low reset
init_busy  output  1  high while the initialisation sweep runs
csb0  input  1  port 0 chip select, active low
web0  input  1  port 0 write enable, active low
wmask0  input  WMASK_WIDTH  port 0 lane write mask
addr0  input  ADDR_WIDTH  port 0 address
din0  input  DATA_WIDTH  port 0 write data
dout0  output  DATA_WIDTH  port 0 read data
dout0_valid  output  1  one-cycle pulse, dout0 carries new read data
csb1  input  1  port 1 chip select, active low
addr1  input  ADDR_WIDTH  port 1 address
dout1  output  DATA_WIDTH  port 1 read data
dout1_valid  output  1  one-cycle pulse, dout1 carries new read data
collision  output  1  pulse aligned with dout1_valid; that read hit a same-edge write

Behaviour:
- Reset (rst_n low, asynchronous):
  - dout0, dout1, dout0_valid, dout1_valid, collision = 0; all pipeline stages cleared.
  - FSM = INIT if INIT_ON_RESET = 1, else READY; init counter = 0.
  - init_busy = 1 if INIT_ON_RESET = 1, else 0.
  - Memory contents are not cleared by reset itself.
- FSM INIT:
  - Each posedge writes INIT_VALUE to mem[counter], then the counter increments.
  - After the edge that writes address 2**ADDR_WIDTH-1, the FSM goes to READY and init_busy drops.
  - init_busy is therefore high for exactly 2**ADDR_WIDTH cycles after rst_n deasserts.
  - During INIT both ports are treated as deselected: no writes, no valids.
  - Reset asserted mid-INIT restarts the sweep from address 0.
- FSM READY: ports are sampled on each posedge; there is no negedge logic.
- Port 0 write (csb0=0, web0=0):
  - Lane i is updated from din0 only when wmask0[i]=1.
  - The result is visible to any read sampled at the next edge or later.
  - wmask0 = 0 is a no-op.
  - dout0 and dout0_valid are unaffected.
- Port 0 read (csb0=0, web0=1): mem[addr0] is sampled at edge T.
  - OUT_REG=0: dout0 is updated at T and dout0_valid is high for cycle T..T+1.
  - OUT_REG=1: both are delayed one more edge.
  - dout0 holds its last value when there is no read.
- Port 1 read (csb1=0): same timing rules as port 0, using dout1 and dout1_valid.
- Collision: port 0 write and port 1 read at the same edge, with addr0 == addr1 and wmask0 != 0.
  - COLLISION_MODE=0: dout1 returns the pre-write word.
  - COLLISION_MODE=1: dout1 returns the merged word (masked lanes from din0, other lanes old).
  - The memory always takes the write.
  - collision pulses with the corresponding dout1_valid, in both modes.
- Both ports reading the same address at the same edge return identical data; this is not a collision.
- Back-to-back reads every cycle give contiguous valid pulses and a full-throughput stream in both OUT_REG settings.
- Addresses wrap naturally in ADDR_WIDTH bits; there is no out-of-range case.

Test Plan:
- INIT_ON_RESET=1, ADDR_WIDTH=8: release rst_n -> init_busy high exactly 256 cycles; then port 1 read 0xFF -> dout1=0x00000000 with dout1_valid 1 cycle later.
- Byte masking, OUT_REG=0: write 0xAABBCCDD to 0x10 with mask 4'b1111, then 0x11223344 with mask 4'b0101; port 0 read 0x10 -> dout0=0xAA22CC44 one cycle after the read edge, dout0_valid single pulse.
- Collision: mem[0x20]=0xAABBCCDD; same-edge port 0 write 0x12345678 (mask 4'b1111) and port 1 read 0x20:
  - COLLISION_MODE=0 -> dout1=0xAABBCCDD, collision=1.
  - COLLISION_MODE=1 -> dout1=0x12345678; with mask 4'b0011 -> 0xAABB5678.
  - A later read of 0x20 returns the written value in both modes.
- OUT_REG=1: port 1 reads 0x1, 0x2, 0x3 on consecutive edges (preloaded 0x11, 0x22, 0x33) -> dout1 = 0x11, 0x22, 0x33 on edges T+1..T+3, dout1_valid high 3 contiguous cycles.
- Reset mid-INIT at cycle 100:
  - outputs go to 0 immediately and init_busy stays high for 256 further cycles.
  - Port 0 write and port 1 read attempted during INIT -> no valid and no memory change (a later read returns INIT_VALUE).
- Dual same-address read of 0x05 (holding 0xDEADBEEF) -> dout0=dout1=0xDEADBEEF, both valids together, collision=0.

Source files
------------

// File: rtl/sram_1rw1r_param_if.sv
// Purpose: bundles the port 0 (read/write) and port 1 (read) buses of sram_1rw1r_param.
// Latency: n/a (wiring only).
// Backpressure: none; the memory accepts one access per port per cycle, except while init_busy is high.
//
// Signals:
//   init_busy              - high while the post-reset initialisation sweep runs
//   csb0/web0/wmask0       - port 0 chip select (low), write enable (low), lane write mask
//   addr0/din0             - port 0 address and write data
//   dout0/dout0_valid      - port 0 read data and one-cycle valid pulse
//   csb1/addr1             - port 1 chip select (low) and address
//   dout1/dout1_valid      - port 1 read data and one-cycle valid pulse
//   collision              - port 1 read hit a same-edge write; aligned with dout1_valid
//
// Modports: master drives requests; slave is the memory.
interface sram_1rw1r_param_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = 4
);
    logic                   init_busy;
    logic                   csb0;
    logic                   web0;
    logic [WMASK_WIDTH-1:0] wmask0;
    logic [ADDR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0]  din0;
    logic [DATA_WIDTH-1:0]  dout0;
    logic                   dout0_valid;
    logic                   csb1;
    logic [ADDR_WIDTH-1:0]  addr1;
    logic [DATA_WIDTH-1:0]  dout1;
    logic                   dout1_valid;
    logic                   collision;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  init_busy, dout0, dout0_valid, dout1, dout1_valid, collision
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output init_busy, dout0, dout0_valid, dout1, dout1_valid, collision
    );
endinterface

// File: rtl/sram_1rw1r_param.sv
// Purpose: parametrised single-clock 1RW+1R synchronous SRAM with masked writes and post-reset init sweep.
// Latency: read data and valid 1 cycle after the sampling edge (2 with OUT_REG=1); writes visible next edge.
// Backpressure: none; both ports are ignored while init_busy is high.
//
// Ports:
//   clk    - single clock, all logic on posedge
//   rst_n  - asynchronous active-low reset (clears outputs and pipeline, restarts init sweep)
//   bus    - sram_1rw1r_param_if slave modport (port 0 RW, port 1 R, status flags)
module sram_1rw1r_param #(
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        ADDR_WIDTH     = 8,
    parameter int                        WMASK_WIDTH    = 4,
    parameter int                        OUT_REG        = 0,
    parameter int                        COLLISION_MODE = 0,
    parameter int                        INIT_ON_RESET  = 1,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE     = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_1rw1r_param_if.slave    bus
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_W = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_init_busy;

    logic                  w_ready;
    logic                  w_wr_en;
    logic                  w_rd0;
    logic                  w_rd1;
    logic                  w_coll;
    logic [DATA_WIDTH-1:0] w_bitmask;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [DATA_WIDTH-1:0] w_rd1_data;

    logic [DATA_WIDTH-1:0] r_d0;
    logic                  r_v0;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_v1;
    logic                  r_c1;

    // Ports are only live in READY and outside reset; INIT behaves as fully deselected.
    assign w_ready = rst_n && (r_state == ST_READY);
    assign w_wr_en = w_ready && !bus.csb0 && !bus.web0;
    assign w_rd0   = w_ready && !bus.csb0 &&  bus.web0;
    assign w_rd1   = w_ready && !bus.csb1;

    always_comb begin
        w_bitmask = '0;
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            w_bitmask[i*LANE_W +: LANE_W] = {LANE_W{bus.wmask0[i]}};
        end
    end

    // Full-word merge of old contents and masked new lanes; an all-zero mask rewrites the old word.
    assign w_wr_merged = (r_mem[bus.addr0] & ~w_bitmask) | (bus.din0 & w_bitmask);

    assign w_coll     = w_wr_en && w_rd1 && (bus.addr0 == bus.addr1) && (|bus.wmask0);
    assign w_rd1_data = ((COLLISION_MODE != 0) && w_coll) ? w_wr_merged : r_mem[bus.addr1];

    // Storage has no reset; the init sweep takes priority over user writes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_INIT) begin
                r_mem[r_init_cnt] <= INIT_VALUE;
            end else if (w_wr_en) begin
                r_mem[bus.addr0] <= w_wr_merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            r_init_cnt  <= '0;
            r_init_busy <= (INIT_ON_RESET != 0);
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
                    if (r_init_cnt == {ADDR_WIDTH{1'b1}}) begin
                        r_state     <= ST_READY;
                        r_init_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0 <= '0;
            r_v0 <= 1'b0;
            r_d1 <= '0;
            r_v1 <= 1'b0;
            r_c1 <= 1'b0;
        end else begin
            r_v0 <= w_rd0;
            r_v1 <= w_rd1;
            r_c1 <= w_coll;
            if (w_rd0) r_d0 <= r_mem[bus.addr0];
            if (w_rd1) r_d1 <= w_rd1_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_d0_q;
            logic                  r_v0_q;
            logic [DATA_WIDTH-1:0] r_d1_q;
            logic                  r_v1_q;
            logic                  r_c1_q;

            // Second stage only loads on a valid so dout holds its last read between accesses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d0_q <= '0;
                    r_v0_q <= 1'b0;
                    r_d1_q <= '0;
                    r_v1_q <= 1'b0;
                    r_c1_q <= 1'b0;
                end else begin
                    r_v0_q <= r_v0;
                    r_v1_q <= r_v1;
                    r_c1_q <= r_c1;
                    if (r_v0) r_d0_q <= r_d0;
                    if (r_v1) r_d1_q <= r_d1;
                end
            end

            assign bus.dout0       = r_d0_q;
            assign bus.dout0_valid = r_v0_q;
            assign bus.dout1       = r_d1_q;
            assign bus.dout1_valid = r_v1_q;
            assign bus.collision   = r_c1_q;
        end else begin : g_no_out_reg
            assign bus.dout0       = r_d0;
            assign bus.dout0_valid = r_v0;
            assign bus.dout1       = r_d1;
            assign bus.dout1_valid = r_v1;
            assign bus.collision   = r_c1;
        end
    endgenerate

    assign bus.init_busy = r_init_busy;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Purpose: self-checking bench for sram_1rw1r_param; two instances share stimulus:
//   dut_a: OUT_REG=0, COLLISION_MODE=0, INIT_VALUE=0
//   dut_b: OUT_REG=1, COLLISION_MODE=1, INIT_VALUE=32'h5A5A0F0F
// Latency: n/a. Backpressure: n/a.
module tb_sram_1rw1r_param;
    localparam logic [31:0] IB = 32'h5A5A_0F0F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4)) ia ();
    sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4)) ib ();

    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4), .OUT_REG(0),
                       .COLLISION_MODE(0), .INIT_ON_RESET(1), .INIT_VALUE(32'h0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));

    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4), .OUT_REG(1),
                       .COLLISION_MODE(1), .INIT_ON_RESET(1), .INIT_VALUE(IB))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    typedef struct {
        logic        csb0;
        logic        web0;
        logic [3:0]  wmask0;
        logic [7:0]  addr0;
        logic [31:0] din0;
        logic        csb1;
        logic [7:0]  addr1;
        logic [31:0] e0a;
        logic [31:0] e0b;
        logic [31:0] e1a;
        logic [31:0] e1b;
        logic        col;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        col;
    } exp_t;

    exp_t q0a[$];
    exp_t q1a[$];
    exp_t q0b[$];
    exp_t q1b[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [31:0] dat,
                       input logic coll, input bit use_coll);
        chk({nm, " cycle"}, 32'(cyc), 32'(e.due));
        chk({nm, " data"}, dat, e.data);
        if (use_coll) chk({nm, " collision"}, {31'b0, coll}, {31'b0, e.col});
    endtask

    // Scoreboard: every output valid must match the queue head, at the cycle it was due.
    task automatic monitor();
        exp_t e;
        if (ia.dout0_valid) begin
            if (q0a.size() == 0) flag("a.p0 unexpected valid");
            else begin e = q0a.pop_front(); cmp("a.p0", e, ia.dout0, 1'b0, 0); end
        end else if (q0a.size() != 0 && q0a[0].due <= cyc) begin
            e = q0a.pop_front(); flag("a.p0 missing valid");
        end
        if (ia.dout1_valid) begin
            if (q1a.size() == 0) flag("a.p1 unexpected valid");
            else begin e = q1a.pop_front(); cmp("a.p1", e, ia.dout1, ia.collision, 1); end
        end else if (q1a.size() != 0 && q1a[0].due <= cyc) begin
            e = q1a.pop_front(); flag("a.p1 missing valid");
        end
        if (ib.dout0_valid) begin
            if (q0b.size() == 0) flag("b.p0 unexpected valid");
            else begin e = q0b.pop_front(); cmp("b.p0", e, ib.dout0, 1'b0, 0); end
        end else if (q0b.size() != 0 && q0b[0].due <= cyc) begin
            e = q0b.pop_front(); flag("b.p0 missing valid");
        end
        if (ib.dout1_valid) begin
            if (q1b.size() == 0) flag("b.p1 unexpected valid");
            else begin e = q1b.pop_front(); cmp("b.p1", e, ib.dout1, ib.collision, 1); end
        end else if (q1b.size() != 0 && q1b[0].due <= cyc) begin
            e = q1b.pop_front(); flag("b.p1 missing valid");
        end
        if (ia.collision && !ia.dout1_valid) flag("a collision without dout1_valid");
        if (ib.collision && !ib.dout1_valid) flag("b collision without dout1_valid");
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic drive(input vec_t v);
        ia.csb0 = v.csb0; ia.web0 = v.web0; ia.wmask0 = v.wmask0; ia.addr0 = v.addr0;
        ia.din0 = v.din0; ia.csb1 = v.csb1; ia.addr1 = v.addr1;
        ib.csb0 = v.csb0; ib.web0 = v.web0; ib.wmask0 = v.wmask0; ib.addr0 = v.addr0;
        ib.din0 = v.din0; ib.csb1 = v.csb1; ib.addr1 = v.addr1;
    endtask

    // Drive one vector and queue the reads it should produce (sampled at the next edge, cyc+1).
    task automatic apply(input vec_t v);
        drive(v);
        if (!v.csb0 && v.web0) begin
            q0a.push_back('{cyc + 1, v.e0a, 1'b0});
            q0b.push_back('{cyc + 2, v.e0b, 1'b0});
        end
        if (!v.csb1) begin
            q1a.push_back('{cyc + 1, v.e1a, v.col});
            q1b.push_back('{cyc + 2, v.e1b, v.col});
        end
        tick();
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        return v;
    endfunction

    // Counts edges until init_busy falls on each DUT; poke=1 tries port accesses late in the sweep.
    task automatic count_init(input bit poke, output int na, output int nb);
        vec_t v;
        int n;
        n = 0; na = 0; nb = 0;
        while (n < 400 && (na == 0 || nb == 0)) begin
            tick();
            n++;
            if (na == 0 && !ia.init_busy) na = n;
            if (nb == 0 && !ib.init_busy) nb = n;
            if (poke && n == 250) begin
                v = '{1'b0, 1'b0, 4'hF, 8'h08, 32'hFFFF_FFFF, 1'b0, 8'h08, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
                drive(v);
            end else begin
                drive(idle_vec());
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " a.dout0"}, ia.dout0, 32'h0);
        chk({nm, " a.dout1"}, ia.dout1, 32'h0);
        chk({nm, " a.valids/coll"}, {29'b0, ia.dout0_valid, ia.dout1_valid, ia.collision}, 32'h0);
        chk({nm, " b.dout0"}, ib.dout0, 32'h0);
        chk({nm, " b.dout1"}, ib.dout1, 32'h0);
        chk({nm, " b.valids/coll"}, {29'b0, ib.dout0_valid, ib.dout1_valid, ib.collision}, 32'h0);
        chk({nm, " init_busy a,b"}, {30'b0, ia.init_busy, ib.init_busy}, 32'h3);
    endtask

    vec_t vt [22];

    initial begin
        int na, nb;

        vt[0]  = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0,         1'b0, 8'hFF, 32'h0, 32'h0, 32'h0, IB, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 4'h0, 8'h08, 32'h0,         1'b1, 8'h00, 32'h0, IB, 32'h0, 32'h0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 4'hF, 8'h10, 32'hAABBCCDD,  1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 4'h5, 8'h10, 32'h11223344,  1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 4'h0, 8'h10, 32'h0,         1'b1, 8'h00, 32'hAA22CC44, 32'hAA22CC44, 32'h0, 32'h0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 4'hF, 8'h20, 32'hAABBCCDD,  1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 4'hF, 8'h21, 32'hAABBCCDD,  1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 4'hF, 8'h20, 32'h12345678,  1'b0, 8'h20, 32'h0, 32'h0, 32'hAABBCCDD, 32'h12345678, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 4'h3, 8'h21, 32'h12345678,  1'b0, 8'h21, 32'h0, 32'h0, 32'hAABBCCDD, 32'hAABB5678, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 4'h0, 8'h20, 32'h0,         1'b0, 8'h21, 32'h12345678, 32'h12345678, 32'hAABB5678, 32'hAABB5678, 1'b0};
        vt[10] = '{1'b0, 1'b0, 4'hF, 8'h05, 32'hDEADBEEF,  1'b0, 8'h30, 32'h0, 32'h0, 32'h0, IB, 1'b0};
        vt[11] = '{1'b0, 1'b1, 4'h0, 8'h05, 32'h0,         1'b0, 8'h05, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vt[12] = '{1'b0, 1'b0, 4'h0, 8'h05, 32'hFFFFFFFF,  1'b0, 8'h05, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vt[13] = '{1'b0, 1'b0, 4'hF, 8'h01, 32'h00000011,  1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[14] = '{1'b0, 1'b0, 4'hF, 8'h02, 32'h00000022,  1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[15] = '{1'b0, 1'b0, 4'hF, 8'h03, 32'h00000033,  1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[16] = '{1'b0, 1'b1, 4'h0, 8'h03, 32'h0,         1'b0, 8'h01, 32'h33, 32'h33, 32'h11, 32'h11, 1'b0};
        vt[17] = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0,         1'b0, 8'h02, 32'h0, 32'h0, 32'h22, 32'h22, 1'b0};
        vt[18] = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0,         1'b0, 8'h03, 32'h0, 32'h0, 32'h33, 32'h33, 1'b0};
        vt[19] = '{1'b1, 1'b0, 4'hF, 8'h05, 32'h0,         1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[20] = idle_vec();
        vt[21] = '{1'b0, 1'b1, 4'h0, 8'h01, 32'h0,         1'b0, 8'h05, 32'h11, 32'h11, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};

        drive(idle_vec());
        tick();
        tick();
        check_reset_outputs("reset");

        // Release, then restart the sweep at cycle 100 with a port access attempted in between.
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 50) drive('{1'b0, 1'b0, 4'hF, 8'h40, 32'h0BADF00D, 1'b0, 8'h40,
                                 32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
            else drive(idle_vec());
        end
        chk("init_busy at cycle 100", {31'b0, ia.init_busy & ib.init_busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid-init reset");
        tick();
        rst_n = 1'b1;
        count_init(1'b1, na, nb);
        chk("a init_busy cycles", 32'(na), 32'd256);
        chk("b init_busy cycles", 32'(nb), 32'd256);

        for (int i = 0; i < 22; i++) apply(vt[i]);
        drive(idle_vec());
        for (int i = 0; i < 5; i++) tick();

        chk("a.dout0 hold", ia.dout0, 32'h11);
        chk("a.dout1 hold", ia.dout1, 32'hDEADBEEF);
        chk("b.dout0 hold", ib.dout0, 32'h11);
        chk("b.dout1 hold", ib.dout1, 32'hDEADBEEF);

        // Asynchronous clear mid-cycle with nonzero outputs, then a full re-sweep.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async reset");
        tick();
        rst_n = 1'b1;
        count_init(1'b0, na, nb);
        chk("a re-init cycles", 32'(na), 32'd256);
        chk("b re-init cycles", 32'(nb), 32'd256);
        apply('{1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h05, 32'h0, IB, 32'h0, IB, 1'b0});
        drive(idle_vec());
        for (int i = 0; i < 5; i++) tick();

        chk("a.p0 queue drained", 32'(q0a.size()), 32'd0);
        chk("a.p1 queue drained", 32'(q1a.size()), 32'd0);
        chk("b.p0 queue drained", 32'(q0b.size()), 32'd0);
        chk("b.p1 queue drained", 32'(q1b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
